// File: rtl/pulse_shaper.sv
// Per-channel trigger pulse generator: rising-edge detect, then delay / width / holdoff timing.
// Optional saturating missed-trigger counters are built when PULSE_SHAPER_STATS_EN is defined.
module pulse_shaper #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 16,
    parameter int unsigned WW = 16,
    parameter int unsigned CW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    in,
    input  logic [N-1:0]    enable,
    input  logic [N*DW-1:0] delay_cfg,
    input  logic [N*WW-1:0] width_cfg,
    input  logic [DW-1:0]   holdoff_cfg,
    output logic [N-1:0]    out,
    output logic [N-1:0]    busy
`ifdef PULSE_SHAPER_STATS_EN
    ,
    output logic [N*CW-1:0] missed_cnt
`endif
);

    localparam int unsigned CTRW = (DW > WW) ? DW : WW;

    typedef enum logic [1:0] {StIdle, StDelay, StActive, StHold} state_e;

    logic [N-1:0] prev_q;
    logic [N-1:0] rise_q;

    // prev resets high so a level already asserted at reset release is not a trigger
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= '1;
            rise_q <= '0;
        end else begin
            prev_q <= in;
            rise_q <= in & ~prev_q;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_e          state_q, state_d;
        logic [CTRW-1:0] cnt_q, cnt_d;
        logic [WW-1:0]   wm1_q, wm1_d;
        logic [DW-1:0]   hold_q, hold_d;
        logic [DW-1:0]   dly;
        logic [WW-1:0]   wcfg;
        logic            out_q, busy_q;

        assign dly  = delay_cfg[i*DW +: DW];
        assign wcfg = width_cfg[i*WW +: WW];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            wm1_d   = wm1_q;
            hold_d  = hold_q;
            if (!enable[i]) begin
                state_d = StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (rise_q[i]) begin
                            // wm1 holds W'-1 where W' = max(width, 1)
                            wm1_d  = (wcfg == '0) ? '0 : wcfg - WW'(1);
                            hold_d = holdoff_cfg;
                            if (dly == '0) begin
                                state_d = StActive;
                                cnt_d   = CTRW'(wm1_d);
                            end else begin
                                state_d = StDelay;
                                cnt_d   = CTRW'(dly - DW'(1));
                            end
                        end
                    end
                    StDelay: begin
                        if (cnt_q == '0) begin
                            state_d = StActive;
                            cnt_d   = CTRW'(wm1_q);
                        end else begin
                            cnt_d = cnt_q - CTRW'(1);
                        end
                    end
                    StActive: begin
                        if (cnt_q == '0) begin
                            if (hold_q == '0) begin
                                state_d = StIdle;
                            end else begin
                                state_d = StHold;
                                cnt_d   = CTRW'(hold_q - DW'(1));
                            end
                        end else begin
                            cnt_d = cnt_q - CTRW'(1);
                        end
                    end
                    StHold: begin
                        if (cnt_q == '0) begin
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q - CTRW'(1);
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                wm1_q   <= '0;
                hold_q  <= '0;
                out_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                wm1_q   <= wm1_d;
                hold_q  <= hold_d;
                out_q   <= (state_d == StActive);
                busy_q  <= (state_d != StIdle);
            end
        end

        assign out[i]  = out_q;
        assign busy[i] = busy_q;

`ifdef PULSE_SHAPER_STATS_EN
        logic          missed;
        logic [CW-1:0] miss_q;

        // an edge coinciding with enable low is dropped, not counted
        assign missed = rise_q[i] & enable[i] & (state_q != StIdle);

        always_ff @(posedge clock) begin
            if (reset) begin
                miss_q <= '0;
            end else if (missed && (miss_q != {CW{1'b1}})) begin
                miss_q <= miss_q + CW'(1);
            end
        end

        assign missed_cnt[i*CW +: CW] = miss_q;
`endif
    end

endmodule

// File: doc/pulse_shaper.md
# pulse_shaper

Per-channel output stage placed directly downstream of the strategy stage. It consumes the strategy's `output_signals_t` vector, detects rising edges on each channel, and emits one timed pulse per accepted edge with a programmable delay, width and holdoff. Its outputs drive the synchronization block's physical trigger lines.

## Interface
- `N`, 8: number of channels, equal to the `output_signals_t` width.
- `DW`, 16: width of the delay and holdoff counters.
- `WW`, 16: width of the pulse-width counter.
- `CW`, 16: width of the missed-trigger counter. Used only with `PULSE_SHAPER_STATS_EN`.

- `clock`  in  1: single clock. Everything is on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `in`  in  N: `output_signals_t` from the strategy stage. Level signals, synchronous to `clock`.
- `enable`  in  N: per-channel enable.
- `delay_cfg`  in  N*DW: per-channel delay D. Channel i uses bits `[i*DW +: DW]`.
- `width_cfg`  in  N*WW: per-channel width W.
- `holdoff_cfg`  in  DW: holdoff H, shared by all channels.
- `out`  out  N: shaped pulses, registered.
- `busy`  out  N: channel is not in IDLE, registered.
- `missed_cnt`  out  N*CW: per-channel count of rejected triggers. Present only with `PULSE_SHAPER_STATS_EN`.

## Operation
- Edge detect: `prev` is a register holding the previous sample of `in`. `rise[i] = in[i] & ~prev[i]`.
- Each channel has its own FSM with states IDLE, DELAY, ACTIVE and HOLD, plus one down-counter of width max(DW, WW).
- **IDLE**: on `rise & enable`:
  - latch W' = max(`width_cfg`, 1) and H from `holdoff_cfg`.
  - If D = 0, go to ACTIVE and load the counter with W'−1.
  - Otherwise go to DELAY and load the counter with D−1.
- **DELAY**: at counter = 0, go to ACTIVE and load W'−1. Otherwise decrement.
- **ACTIVE**: `out` = 1. At counter = 0:
  - if H = 0, go to IDLE;
  - otherwise go to HOLD and load H−1.
  - Otherwise decrement.
- **HOLD**: `out` = 0. At counter = 0, go to IDLE. Otherwise decrement.
- A `rise` in DELAY, ACTIVE or HOLD is ignored and counted as missed. It never restarts or extends a pulse.
- A `rise` in IDLE with `enable` = 0 is dropped and not counted.
- `enable` deasserted in any state: the channel goes to IDLE on the next edge and `out` is 0 from that edge on. This has priority over counter expiry. An edge in the same cycle is not counted.
- Configuration inputs are latched only when a trigger is accepted. Changing them mid-pulse has no effect on the current pulse.
- Channels are fully independent. There is no shared arbitration.

## Timing
- Reset values: `out` = 0, `busy` = 0, all FSMs in IDLE, counters 0, `missed_cnt` = 0.
- `prev` resets to all ones, so a level already high at reset release is not a trigger.
- Let edge k be the clock edge at which `in[i]` = 1 is sampled with `prev[i]` = 0.
  - `out[i]` rises at edge k+1+D and stays high for exactly W' cycles.
  - A new trigger is accepted no earlier than edge k+1+D+W'+H.
- `busy[i]` is 1 from edge k+1 until the edge at which the FSM returns to IDLE.
- Back-to-back case with D = 0, W' = 1, H = 0: a rise can be accepted every 2 cycles at most. `in` toggling 1,0,1,0 gives one pulse per high phase.
- Reset asserted mid-pulse: `out` = 0 at the next edge. A pending delay is discarded.

## Configuration
- `PULSE_SHAPER_STATS_EN` defined:
  - each channel has a CW-bit `missed_cnt` that increments on every ignored `rise`;
  - it saturates at 2^CW−1, never wraps, and clears only on `reset`.
- Undefined: the `missed_cnt` port and all counter logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset release with `in[0]` held high, `enable` = 1 → no pulse. After `in[0]` goes low and then high, a pulse appears.
- Ch0, D = 3, W = 2, H = 0, single rise sampled at edge 10 → `out[0]` = 1 after edges 14 and 15, 0 after edge 16. `busy[0]` = 1 after edges 11–15.
- Ch1, D = 0, W = 0 → a one-cycle pulse after edge k+1, because W is treated as 1.
- Ch2, D = 2, W = 4, H = 5; second rise during ACTIVE and third during HOLD → exactly one pulse. With stats enabled, `missed_cnt[2]` = 2. A fourth rise after HOLD ends gives a second pulse.
- `enable[3]` cleared during DELAY → no pulse and `busy[3]` = 0 on the next edge. The same test with `reset` instead of clearing `enable` gives the same result.
- Stats with CW = 2 and six ignored rises → `missed_cnt` = 3, saturated.
